// File: rtl/ysyx_22040759_axi_arbiter.sv
// ysyx_22040759_axi_arbiter: shares the single AXI rw bridge
// between the fetch (if_*) and data-memory (mem_*) requesters.
module ysyx_22040759_axi_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 64
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_valid,
    input  logic [AW-1:0] if_addr,
    input  logic [1:0]    if_size,
    output logic          if_ready,
    output logic [63:0]   if_data_read,
    output logic [1:0]    if_resp,

    input  logic          mem_valid,
    input  logic          mem_req,
    input  logic [AW-1:0] mem_addr,
    input  logic [1:0]    mem_size,
    input  logic [63:0]   mem_wdata,
    input  logic [7:0]    mem_wmask,
    output logic          mem_ready,
    output logic [63:0]   mem_data_read,
    output logic [1:0]    mem_resp,

    output logic          rw_valid,
    output logic          rw_req,
    output logic [AW-1:0] rw_addr,
    output logic [1:0]    rw_size,
    output logic [63:0]   rw_wdata,
    output logic [7:0]    rw_wmask,
    input  logic          rw_ready,
    input  logic [63:0]   rw_data_read,
    input  logic [1:0]    rw_resp
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_IF,
        GNT_MEM
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic [3:0] starve_nxt;

    logic       tie;
    logic       pick_if;
    logic       pick_mem;
    logic       if_done;
    logic       mem_done;

    // Winner selection in IDLE: MEM wins ties until IF has lost LIMIT ties
    always_comb begin
        tie      = if_valid && mem_valid;
        pick_if  = if_valid && (!mem_valid || (starve_cnt == LIMIT));
        pick_mem = mem_valid && !pick_if;
    end

    // Next-state logic: grant from IDLE, release on bridge completion
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pick_if) begin
                    state_nxt = GNT_IF;
                end else if (pick_mem) begin
                    state_nxt = GNT_MEM;
                end
            end
            GNT_IF, GNT_MEM: begin
                if (rw_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Starvation counter: counts ties lost by IF, cleared by any IF win
    always_comb begin
        starve_nxt = starve_cnt;
        if (state == IDLE) begin
            if (pick_if) begin
                starve_nxt = '0;
            end else if (tie && (starve_cnt < LIMIT)) begin
                starve_nxt = starve_cnt + 4'd1;
            end
        end
    end

    // State and starvation counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Registered bridge request: loaded on grant, held until completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_valid <= 1'b0;
            rw_req   <= 1'b0;
            rw_addr  <= '0;
            rw_size  <= '0;
            rw_wdata <= '0;
            rw_wmask <= '0;
        end else if (state == IDLE) begin
            if (pick_if) begin
                rw_valid <= 1'b1;
                rw_req   <= 1'b0;
                rw_addr  <= if_addr;
                rw_size  <= if_size;
                rw_wdata <= '0;
                rw_wmask <= '0;
            end else if (pick_mem) begin
                rw_valid <= 1'b1;
                rw_req   <= mem_req;
                rw_addr  <= mem_addr;
                rw_size  <= mem_size;
                rw_wdata <= mem_wdata;
                rw_wmask <= mem_wmask;
            end
        end else if (rw_ready) begin
            rw_valid <= 1'b0;
        end
    end

    // Completion is routed only to a granted requester still asking
    always_comb begin
        if_done  = (state == GNT_IF) && rw_ready && if_valid;
        mem_done = (state == GNT_MEM) && rw_ready && mem_valid;
    end

    // Response steering: non-granted outputs stay zero
    always_comb begin
        if_ready      = 1'b0;
        if_data_read  = '0;
        if_resp       = '0;
        mem_ready     = 1'b0;
        mem_data_read = '0;
        mem_resp      = '0;
        unique case (1'b1)
            if_done: begin
                if_ready     = 1'b1;
                if_data_read = rw_data_read;
                if_resp      = rw_resp;
            end
            mem_done: begin
                mem_ready     = 1'b1;
                mem_data_read = rw_data_read;
                mem_resp      = rw_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22040759_axi_arbiter.sv
// tb_ysyx_22040759_axi_arbiter: scoreboard bench with a
// transaction-level arbitration model and a random bridge.
module tb_ysyx_22040759_axi_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [63:0] if_addr;
    logic [1:0]  if_size;
    logic        if_ready;
    logic [63:0] if_data_read;
    logic [1:0]  if_resp;
    logic        mem_valid;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [1:0]  mem_size;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready;
    logic [63:0] mem_data_read;
    logic [1:0]  mem_resp;
    logic        rw_valid;
    logic        rw_req;
    logic [63:0] rw_addr;
    logic [1:0]  rw_size;
    logic [63:0] rw_wdata;
    logic [7:0]  rw_wmask;
    logic        rw_ready;
    logic [63:0] rw_data_read;
    logic [1:0]  rw_resp;

    ysyx_22040759_axi_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .AW(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_valid(if_valid),
        .if_addr(if_addr),
        .if_size(if_size),
        .if_ready(if_ready),
        .if_data_read(if_data_read),
        .if_resp(if_resp),
        .mem_valid(mem_valid),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_size(mem_size),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_ready(mem_ready),
        .mem_data_read(mem_data_read),
        .mem_resp(mem_resp),
        .rw_valid(rw_valid),
        .rw_req(rw_req),
        .rw_addr(rw_addr),
        .rw_size(rw_size),
        .rw_wdata(rw_wdata),
        .rw_wmask(rw_wmask),
        .rw_ready(rw_ready),
        .rw_data_read(rw_data_read),
        .rw_resp(rw_resp)
    );

    typedef struct {
        bit          who_if;
        logic [63:0] addr;
        logic        req;
        logic [1:0]  size;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          cyc;
    } gnt_t;

    typedef struct {
        bit          who_if;
        logic [63:0] data;
        logic [1:0]  resp;
    } done_t;

    gnt_t  gq[$];
    done_t dq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit busy_m = 0;
    bit gnt_if_m = 0;
    int starve_m = 0;

    bit bridge_en = 1;
    int bdly = -1;
    bit pending = 0;
    int bcnt = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d want done", cyc);
        $fatal(1, "timeout");
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bridge: answers each request after 0..3 cycles with random data
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            pending = 0;
        end else if (bridge_en) begin
            if (rw_ready) begin
                rw_ready = 0;
                pending = 0;
            end else if (rw_valid) begin
                if (!pending) begin
                    pending = 1;
                    bcnt = (bdly < 0) ? $urandom_range(0, 3) : bdly;
                end
                if (bcnt == 0) begin
                    rw_ready = 1;
                    rw_data_read = {$urandom, $urandom};
                    rw_resp = 2'($urandom_range(0, 3));
                end else begin
                    bcnt--;
                end
            end
        end
    end

    // Reference model: one outstanding transaction, MEM wins ties
    // unless IF has lost LIMIT ties in a row
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (!busy_m) begin
                if (if_valid || mem_valid) begin
                    gnt_t g;
                    bit pick;
                    pick = if_valid && (!mem_valid || starve_m == LIMIT);
                    if (pick) starve_m = 0;
                    else if (if_valid) starve_m++;
                    g.who_if = pick;
                    g.addr = pick ? if_addr : mem_addr;
                    g.req = pick ? 1'b0 : mem_req;
                    g.size = pick ? if_size : mem_size;
                    g.wdata = mem_wdata;
                    g.wmask = pick ? 8'h00 : mem_wmask;
                    g.cyc = cyc;
                    gq.push_back(g);
                    busy_m = 1;
                    gnt_if_m = pick;
                end
            end else if (rw_ready) begin
                busy_m = 0;
                if (gnt_if_m ? if_valid : mem_valid) begin
                    done_t d;
                    d.who_if = gnt_if_m;
                    d.data = rw_data_read;
                    d.resp = rw_resp;
                    dq.push_back(d);
                end
            end
        end
    end

    // Monitor: compares bridge requests and ready pulses to the queues
    initial begin
        bit prev_rv = 0;
        gnt_t h;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_rv = 0;
            end else begin
                bit ei;
                bit em;
                done_t e;
                if (rw_valid && !prev_rv) begin
                    if (gq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexp_grant got addr %0h want none",
                                 rw_addr);
                    end else begin
                        h = gq.pop_front();
                        chk("gnt_lat", 64'(cyc), 64'(h.cyc + 1));
                        chk("gnt_addr", rw_addr, h.addr);
                        chk("gnt_req", 64'(rw_req), 64'(h.req));
                        chk("gnt_size", 64'(rw_size), 64'(h.size));
                        chk("gnt_wmask", 64'(rw_wmask), 64'(h.wmask));
                        if (!h.who_if) chk("gnt_wdata", rw_wdata, h.wdata);
                    end
                end else if (rw_valid) begin
                    chk("hold_addr", rw_addr, h.addr);
                    chk("hold_wmask", 64'(rw_wmask), 64'(h.wmask));
                end
                prev_rv = rw_valid;
                ei = 0;
                em = 0;
                e.data = '0;
                e.resp = '0;
                if (dq.size() > 0) begin
                    e = dq.pop_front();
                    ei = e.who_if;
                    em = !e.who_if;
                end
                chk("if_ready", 64'(if_ready), 64'(ei));
                chk("mem_ready", 64'(mem_ready), 64'(em));
                chk("if_data", if_data_read, ei ? e.data : 64'h0);
                chk("if_resp", 64'(if_resp), ei ? 64'(e.resp) : 64'h0);
                chk("mem_data", mem_data_read, em ? e.data : 64'h0);
                chk("mem_resp", 64'(mem_resp), em ? 64'(e.resp) : 64'h0);
            end
        end
    end

    task automatic wait_if();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!if_ready && t < 100);
        if (!if_ready) begin
            checks++;
            errors++;
            $display("FAIL if_timeout got %0d want <100", t);
        end
    endtask

    task automatic wait_mem();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mem_ready && t < 100);
        if (!mem_ready) begin
            checks++;
            errors++;
            $display("FAIL mem_timeout got %0d want <100", t);
        end
    endtask

    task automatic wait_rv();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rw_valid && t < 20);
        if (!rw_valid) begin
            checks++;
            errors++;
            $display("FAIL rv_timeout got %0d want <20", t);
        end
    endtask

    task automatic rand_mem();
        mem_req = 1'($urandom);
        mem_addr = {32'h0, $urandom};
        mem_size = 2'($urandom_range(0, 3));
        mem_wdata = {$urandom, $urandom};
        mem_wmask = 8'($urandom);
    endtask

    task automatic run_if(input int n, input int gmax);
        for (int i = 0; i < n; i++) begin
            int g;
            if_addr = {32'h0, $urandom};
            if_size = 2'($urandom_range(0, 3));
            if_valid = 1;
            wait_if();
            @(posedge clk);
            #1;
            g = $urandom_range(0, gmax);
            if (g > 0) begin
                if_valid = 0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        if_valid = 0;
    endtask

    task automatic run_mem(input int n, input int gmax);
        for (int i = 0; i < n; i++) begin
            int g;
            rand_mem();
            mem_valid = 1;
            wait_mem();
            @(posedge clk);
            #1;
            g = $urandom_range(0, gmax);
            if (g > 0) begin
                mem_valid = 0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        mem_valid = 0;
    endtask

    initial begin
        rst = 1;
        if_valid = 0;
        if_addr = '0;
        if_size = '0;
        mem_valid = 0;
        mem_req = 0;
        mem_addr = '0;
        mem_size = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        rw_ready = 0;
        rw_data_read = '0;
        rw_resp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rw_valid", 64'(rw_valid), 64'h0);
        chk("rst_rw_addr", rw_addr, 64'h0);
        chk("rst_rw_req", 64'(rw_req), 64'h0);
        chk("rst_rw_wdata", rw_wdata, 64'h0);
        chk("rst_rw_wmask", 64'(rw_wmask), 64'h0);
        chk("rst_if_ready", 64'(if_ready), 64'h0);
        chk("rst_mem_ready", 64'(mem_ready), 64'h0);
        @(posedge clk);
        #1;
        rst = 0;

        // Fetch alone, bridge answers two cycles later
        bdly = 2;
        @(posedge clk);
        #1;
        if_addr = 64'h8000_0000;
        if_size = 2'd2;
        if_valid = 1;
        wait_if();
        @(posedge clk);
        #1;
        if_valid = 0;

        // Simultaneous requests: MEM write first, IF after an idle cycle
        repeat (2) @(posedge clk);
        #1;
        mem_req = 1;
        mem_addr = 64'h8000_1000;
        mem_size = 2'd3;
        mem_wdata = 64'h1122_3344_5566_7788;
        mem_wmask = 8'hFF;
        if_addr = 64'h8000_0004;
        if_size = 2'd2;
        mem_valid = 1;
        if_valid = 1;
        fork
            begin
                wait_mem();
                @(posedge clk);
                #1;
                mem_valid = 0;
            end
            begin
                wait_if();
                @(posedge clk);
                #1;
                if_valid = 0;
            end
        join

        // Random traffic with random bridge latency
        bdly = -1;
        fork
            run_if(40, 3);
            run_mem(40, 3);
        join

        // Continuous contention exercises the starvation limit
        repeat (2) @(posedge clk);
        #1;
        fork
            run_if(6, 0);
            run_mem(30, 0);
        join

        // MEM drops its request while granted; IF follows
        repeat (2) @(posedge clk);
        #1;
        bdly = 3;
        rand_mem();
        mem_valid = 1;
        wait_rv();
        @(posedge clk);
        #1;
        mem_valid = 0;
        if_addr = 64'h8000_0100;
        if_size = 2'd2;
        if_valid = 1;
        wait_if();
        @(posedge clk);
        #1;
        if_valid = 0;
        bdly = -1;

        // Reset while IF is granted and the bridge is silent
        repeat (3) @(posedge clk);
        #1;
        bridge_en = 0;
        if_addr = 64'h8000_0200;
        if_valid = 1;
        wait_rv();
        #3;
        rst = 1;
        #1;
        chk("arst_rw_valid", 64'(rw_valid), 64'h0);
        chk("arst_rw_addr", rw_addr, 64'h0);
        chk("arst_if_ready", 64'(if_ready), 64'h0);
        @(posedge clk);
        #1;
        if_valid = 0;
        rst = 0;
        busy_m = 0;
        starve_m = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(rw_valid), 64'h0);
        end

        // Stray bridge ready while idle must be ignored
        @(posedge clk);
        #1;
        rw_ready = 1;
        rw_data_read = 64'hDEAD_BEEF_0000_0001;
        rw_resp = 2'd1;
        @(posedge clk);
        #1;
        rw_ready = 0;
        repeat (2) begin
            @(negedge clk);
            chk("idle_rw_valid", 64'(rw_valid), 64'h0);
        end
        bridge_en = 1;
        @(posedge clk);
        #1;
        fork
            run_if(3, 1);
            run_mem(3, 1);
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        #3;
        chk("gq_empty", 64'(gq.size()), 64'h0);
        chk("dq_empty", 64'(dq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
